muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 135 +++++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply / unsigned divide / remainder unit with valid-ready handshakes.
// Define MULDIV_ZERO_BYPASS_EN to finish legal ops with a zero operand in one cycle.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        negative
);
    localparam logic [3:0] OP_MUL = 4'b1011;
    localparam logic [3:0] OP_DIV = 4'b1101;
    localparam logic [3:0] OP_REM = 4'b1110;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg;
    logic [3:0]  op_reg;
    logic        bzero_reg;
    logic [31:0] acc_reg;   // product (MUL) or partial remainder (DIV/REM)
    logic [31:0] sh_reg;    // multiplier shifting right, or dividend/quotient shifting left
    logic [31:0] dv_reg;    // multiplicand shifting left, or divisor
    logic [31:0] result_reg;

    logic        accept, legal, bypass, last_iter;
    logic [31:0] mul_acc;
    logic [32:0] rem_sh, diff;
    logic        ge;
    logic [31:0] div_acc, div_sh, final_res;

    assign accept    = in_valid && in_ready;
    assign legal     = (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
    assign last_iter = (cnt_reg == 5'd31);

`ifdef MULDIV_ZERO_BYPASS_EN
    assign bypass = (a == 32'd0) || (b == 32'd0);
`else
    assign bypass = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = (!legal || bypass) ? DONE : RUN;
            RUN:  if (last_iter) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
    end

    // One shift-add or restoring-division step per cycle
    always_comb begin
        mul_acc = acc_reg + (sh_reg[0] ? dv_reg : 32'd0);
        rem_sh  = {acc_reg, sh_reg[31]};
        diff    = rem_sh - {1'b0, dv_reg};
        // The shifted remainder stays below twice the divisor, so bit 32 is a clean borrow.
        ge      = ~diff[32];
        div_acc = ge ? diff[31:0] : rem_sh[31:0];
        div_sh  = {sh_reg[30:0], ge};
        case (op_reg)
            OP_MUL:  final_res = mul_acc;
            OP_DIV:  final_res = bzero_reg ? 32'd0 : div_sh;
            OP_REM:  final_res = bzero_reg ? 32'd0 : div_acc;
            default: final_res = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= 5'd0;
            op_reg     <= 4'd0;
            bzero_reg  <= 1'b0;
            acc_reg    <= 32'd0;
            sh_reg     <= 32'd0;
            dv_reg     <= 32'd0;
            result_reg <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg    <= op;
                        bzero_reg <= (b == 32'd0);
                        cnt_reg   <= 5'd0;
                        acc_reg   <= 32'd0;
                        if (op == OP_MUL) begin
                            sh_reg <= b;
                            dv_reg <= a;
                        end else begin
                            sh_reg <= a;
                            dv_reg <= b;
                        end
                        if (!legal || bypass) result_reg <= 32'd0;
                    end
                end
                RUN: begin
                    cnt_reg <= cnt_reg + 5'd1;
                    if (op_reg == OP_MUL) begin
                        acc_reg <= mul_acc;
                        sh_reg  <= {1'b0, sh_reg[31:1]};
                        dv_reg  <= {dv_reg[30:0], 1'b0};
                    end else begin
                        acc_reg <= div_acc;
                        sh_reg  <= div_sh;
                    end
                    if (last_iter) result_reg <= final_res;
                end
                default: ;
            endcase
        end
    end

    assign result   = result_reg;
    assign zero     = (result_reg == 32'd0);
    assign negative = result_reg[31];
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a plain-arithmetic reference model.
module tb_muldiv_unit;
    localparam logic [3:0] OP_MUL = 4'b1011;
    localparam logic [3:0] OP_DIV = 4'b1101;
    localparam logic [3:0] OP_REM = 4'b1110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        negative;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .negative(negative)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_res(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            OP_MUL:  return x * y;
            OP_DIV:  return (y == 0) ? 32'd0 : x / y;
            OP_REM:  return (y == 0) ? 32'd0 : x % y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o != OP_MUL && o != OP_DIV && o != OP_REM) return 1;
`ifdef MULDIV_ZERO_BYPASS_EN
        if (x == 0 || y == 0) return 1;
`endif
        return 33;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: busy flag, cycles still to wait, and the expected answer
    logic        m_busy = 1'b0;
    int          m_left = 0;
    logic [31:0] m_res  = 32'd0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_res  <= ref_res(op, a, b);
                m_left <= ref_lat(op, a, b) - 1;
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
        end else if (out_ready) begin
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
            chk("out_valid", {31'd0, out_valid}, {31'd0, (m_busy && m_left == 0)});
            if (m_busy && m_left == 0) begin
                chk("result", result, m_res);
                chk("zero", {31'd0, zero}, {31'd0, (m_res == 0)});
                chk("negative", {31'd0, negative}, {31'd0, m_res[31]});
            end
        end
    end

    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int hold,
                          output logic [31:0] res, output logic z, output logic n, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a  = $urandom;
        b  = $urandom;
        op = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            in_valid = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        res = result;
        z   = zero;
        n   = negative;
        repeat (hold) begin
            in_valid = 1'($urandom);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        $display("op=%b a=%h b=%h -> result=%h latency=%0d", o, x, y, res, lat);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [31:0] r;
    logic        z, n, seen;
    int          lat;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_negative", {31'd0, negative}, 32'd0);

        run_op(OP_MUL, 32'd7, 32'd6, 0, r, z, n, lat);
        chk("mul7x6", r, 32'd42);
        chk("mul7x6_zero", {31'd0, z}, 32'd0);
        chk("mul7x6_lat", lat, 33);

        run_op(OP_DIV, 32'd100, 32'd7, 0, r, z, n, lat);
        chk("div100_7", r, 32'd14);
        run_op(OP_REM, 32'd100, 32'd7, 0, r, z, n, lat);
        chk("rem100_7", r, 32'd2);
        run_op(OP_MUL, 32'hFFFFFFFF, 32'd2, 0, r, z, n, lat);
        chk("mul_ffff_2", r, 32'hFFFFFFFE);
        chk("mul_ffff_2_neg", {31'd0, n}, 32'd1);

        run_op(OP_DIV, 32'd5, 32'd0, 0, r, z, n, lat);
        chk("div_by_zero", r, 32'd0);
        chk("div_by_zero_zero", {31'd0, z}, 32'd1);
`ifdef MULDIV_ZERO_BYPASS_EN
        chk("div_by_zero_lat", lat, 1);
`else
        chk("div_by_zero_lat", lat, 33);
`endif
        run_op(4'b0000, 32'd12, 32'd34, 0, r, z, n, lat);
        chk("illegal_op", r, 32'd0);
        chk("illegal_op_lat", lat, 1);

        run_op(OP_MUL, 32'd3, 32'd5, 10, r, z, n, lat);
        chk("mul3x5_held", r, 32'd15);
        chk("mul3x5_idle_after", {31'd0, in_ready}, 32'd1);

        // Abort a division mid-iteration with a reset pulse
        @(negedge clk);
        in_valid = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", {31'd0, seen}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_zero", {31'd0, zero}, 32'd1);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
        run_op(OP_DIV, 32'd9, 32'd3, 0, r, z, n, lat);
        chk("div9_3", r, 32'd3);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  ro;
            logic [31:0] ra, rb;
            case ($urandom % 4)
                0: ro = OP_MUL;
                1: ro = OP_DIV;
                2: ro = OP_REM;
                default: ro = 4'($urandom);
            endcase
            case ($urandom % 4)
                0: ra = 32'd0;
                1: ra = $urandom % 1000;
                default: ra = $urandom;
            endcase
            case ($urandom % 4)
                0: rb = 32'd0;
                1: rb = $urandom % 100;
                default: rb = $urandom >> ($urandom % 32);
            endcase
            run_op(ro, ra, rb, int'($urandom % 4), r, z, n, lat);
            chk("rand_result", r, ref_res(ro, ra, rb));
            chk("rand_lat", lat, ref_lat(ro, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
